// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze.
// Latency: stall/flush/hold controls are combinational, valid in the detection cycle.
// Backpressure: mem_busy freezes the whole pipe; counters and watchdog update on the next edge.
module hazard_ctrl #(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      ex_inst,
   input  logic             br_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             hang_err
);

   localparam int            WW       = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic          lu, stall_inc, flush_inc;
   logic [4:0]    ex_rd;
   logic          unused_bits;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
   endfunction

   // Load in EX whose destination is a source of the instruction in ID; x0 never hazards.
   assign ex_rd = ex_inst[11:7];
   assign lu    = (ex_inst[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                  ((uses_rs1(id_inst[6:0]) && (id_inst[19:15] == ex_rd)) ||
                   (uses_rs2(id_inst[6:0]) && (id_inst[24:20] == ex_rd)));

   // Fields not involved in hazard detection.
   assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

   // Prioritised control decode: reset, memory hold, flush, load-use stall, default.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      state_nxt   = RUN;
      if (rstn) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pipe_hold  = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         state_nxt  = MEM_WAIT;
      end else if (br_taken) begin
         // The dependent instruction is on the wrong path, so a flush wins over lu.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_inc   = 1'b1;
      end else if (lu && (state != LU_STALL)) begin
         // In LU_STALL the EX slot holds the bubble we inserted, so lu is stale.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         state_nxt   = LU_STALL;
      end
   end

   // Consecutive busy-cycle count for the watchdog, saturating at MAX_WAIT.
   always_comb begin
      wait_nxt = '0;
      if (mem_busy)
         wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
   end

   // State, saturating performance counters and sticky hang flag.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state     <= RUN;
         wait_cnt  <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         hang_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (mem_busy && (wait_nxt == WAIT_MAX))
            hang_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] LW_X5   = 32'h0000_A283;
   localparam logic [31:0] ADD_X5  = 32'h0072_8333;
   localparam logic [4:0]  C_DEF   = 5'b11000;  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
   localparam logic [4:0]  C_STALL = 5'b00010;
   localparam logic [4:0]  C_FLUSH = 5'b11110;
   localparam logic [4:0]  C_HOLD  = 5'b00001;
   localparam logic [4:0]  C_RST   = 5'b00110;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] id_inst, ex_inst;
   logic        br_taken, mem_busy;

   logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, hang_err;
   logic [15:0] stall_cnt, flush_cnt;
   logic        w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble, w_pipe_hold, w_hang_err;
   logic [3:0]  w_stall_cnt, w_flush_cnt;

   int nvec = 0;
   int nerr = 0;

   hazard_ctrl dut (
      .clk(clk), .rstn(rstn), .id_inst(id_inst), .ex_inst(ex_inst),
      .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang_err(hang_err)
   );

   hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut_w (
      .clk(clk), .rstn(rstn), .id_inst(id_inst), .ex_inst(ex_inst),
      .br_taken(br_taken), .mem_busy(mem_busy),
      .pc_write(w_pc_write), .ifid_write(w_ifid_write), .ifid_flush(w_ifid_flush),
      .idex_bubble(w_idex_bubble), .pipe_hold(w_pipe_hold),
      .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt), .hang_err(w_hang_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_ctl(input string nm, input logic [4:0] exp);
      chk(nm, {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}, exp);
      chk({nm, "_w"}, {w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble, w_pipe_hold}, exp);
   endtask

   task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic br, input logic busy);
      id_inst  = id;
      ex_inst  = ex;
      br_taken = br;
      mem_busy = busy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      drive(NOP, NOP, 1'b0, 1'b0);
      tick();
      rstn = 1'b0;
   endtask

   // Reference: load-use rule written straight from the ISA field definitions.
   function automatic logic model_lu(input logic [31:0] id, input logic [31:0] ex);
      logic [4:0] rd;
      logic [6:0] op;
      logic       r1, r2;
      rd = ex[11:7];
      op = id[6:0];
      r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
      r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
      return (ex[6:0] == 7'b0000011) && (rd != 0) &&
             ((r1 && id[19:15] == rd) || (r2 && id[24:20] == rd));
   endfunction

   typedef struct {
      logic [31:0] id;
      logic [31:0] ex;
      logic        br;
      logic        busy;
      logic [4:0]  ctl;
      string       nm;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic       m_just;
      int         m_st, m_fl, m_run;
      logic       m_h4, m_h64;
      logic [4:0] exp_ctl;
      logic [6:0] ops[10];
      logic [31:0] r;
      logic [31:0] rid, rex;
      logic       rbr, rbusy;

      // ---- reset state ----
      rstn = 1'b1;
      drive(NOP, NOP, 1'b0, 1'b0);
      #3;
      chk_ctl("rst_ctl", C_RST);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_flush", flush_cnt, 0);
      chk("rst_hang", hang_err, 0);
      tick();
      rstn = 1'b0;

      // ---- no false stalls ----
      drive(ADD_X5, 32'h0000_A003, 1'b0, 1'b0); #3; chk_ctl("lw_x0", C_DEF); tick();
      drive(32'h0002_A2B7, LW_X5, 1'b0, 1'b0);  #3; chk_ctl("lui_rs1f", C_DEF); tick();
      drive(NOP, NOP, 1'b0, 1'b0); #3; chk("nostall_cnt", stall_cnt, 0); tick();

      // ---- load-use on rs1: exactly one stall cycle ----
      drive(ADD_X5, LW_X5, 1'b0, 1'b0); #3; chk_ctl("lu_rs1", C_STALL); tick();
      drive(ADD_X5, NOP, 1'b0, 1'b0);   #3; chk_ctl("lu_after", C_DEF);
      chk("lu_stall_cnt", stall_cnt, 1); tick();

      // ---- async reset while in LU_STALL ----
      drive(ADD_X5, LW_X5, 1'b0, 1'b0); #3; tick();
      drive(ADD_X5, NOP, 1'b0, 1'b0);
      #1 rstn = 1'b1;
      #1;
      chk_ctl("arst_ctl", C_RST);
      chk("arst_stall", stall_cnt, 0);
      chk("arst_flush", flush_cnt, 0);
      rstn = 1'b0;
      #1;
      tick();
      drive(ADD_X5, LW_X5, 1'b0, 1'b0); #3; chk_ctl("arst_run", C_STALL); tick();
      drive(NOP, NOP, 1'b0, 1'b0); #3; tick();

      // ---- branch beats load-use ----
      do_reset();
      drive(ADD_X5, LW_X5, 1'b1, 1'b0); #3; chk_ctl("br_lu", C_FLUSH); tick();
      drive(NOP, NOP, 1'b0, 1'b0); #3;
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 0);
      tick();

      // ---- memory wait over a load-use pair ----
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(ADD_X5, LW_X5, 1'b0, 1'b1); #3; chk_ctl($sformatf("memwait_%0d", i), C_HOLD); tick();
      end
      drive(ADD_X5, LW_X5, 1'b0, 1'b0); #3; chk_ctl("memwait_lu", C_STALL); tick();
      drive(ADD_X5, NOP, 1'b0, 1'b0);   #3; chk_ctl("memwait_after", C_DEF);
      chk("memwait_stall", stall_cnt, 1);
      chk("memwait_hang", hang_err, 0);
      tick();

      // ---- watchdog (MAX_WAIT=4 instance) ----
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(NOP, NOP, 1'b0, 1'b1); #3;
         if (i == 3) chk("wd_before", w_hang_err, 0);
         if (i == 5) chk("wd_set", w_hang_err, 1);
         tick();
      end
      drive(NOP, NOP, 1'b0, 1'b0); #3;
      chk("wd_sticky", w_hang_err, 1);
      chk("wd_big_clear", hang_err, 0);
      tick(); tick();
      chk("wd_sticky2", w_hang_err, 1);
      rstn = 1'b1; #1;
      chk("wd_rst", w_hang_err, 0);
      rstn = 1'b0;
      tick();

      // ---- single-cycle decode table, each from RUN ----
      vecs.push_back('{ADD_X5,        LW_X5,         1'b0, 1'b0, C_STALL, "t_rs1"});
      vecs.push_back('{32'h00538333,  LW_X5,         1'b0, 1'b0, C_STALL, "t_rs2_add"});
      vecs.push_back('{32'h00538313,  LW_X5,         1'b0, 1'b0, C_DEF,   "t_addi_rs2f"});
      vecs.push_back('{32'h0053A023,  LW_X5,         1'b0, 1'b0, C_STALL, "t_sw_rs2"});
      vecs.push_back('{32'h0002806F,  LW_X5,         1'b0, 1'b0, C_DEF,   "t_jal"});
      vecs.push_back('{32'h00028097,  LW_X5,         1'b0, 1'b0, C_DEF,   "t_auipc"});
      vecs.push_back('{32'h000280E7,  LW_X5,         1'b0, 1'b0, C_STALL, "t_jalr"});
      vecs.push_back('{ADD_X5,        32'h00508293,  1'b0, 1'b0, C_DEF,   "t_not_load"});
      vecs.push_back('{ADD_X5,        LW_X5,         1'b1, 1'b0, C_FLUSH, "t_br"});
      vecs.push_back('{ADD_X5,        LW_X5,         1'b0, 1'b1, C_HOLD,  "t_busy"});
      vecs.push_back('{ADD_X5,        LW_X5,         1'b1, 1'b1, C_HOLD,  "t_busy_br"});
      vecs.push_back('{NOP,           NOP,           1'b0, 1'b0, C_DEF,   "t_nop"});
      do_reset();
      foreach (vecs[k]) begin
         drive(vecs[k].id, vecs[k].ex, vecs[k].br, vecs[k].busy); #3;
         chk_ctl(vecs[k].nm, vecs[k].ctl);
         tick();
         drive(NOP, NOP, 1'b0, 1'b0); #3; tick();
      end

      // ---- randomized run against the reference model ----
      ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
      do_reset();
      m_just = 1'b0; m_st = 0; m_fl = 0; m_run = 0; m_h4 = 1'b0; m_h64 = 1'b0;
      rbusy = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r   = $urandom();
         rex = {r[31:12], 5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b0110011};
         r   = $urandom();
         rid = {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:7], ops[$urandom_range(0, 9)]};
         rbr = ($urandom_range(0, 5) == 0);
         rbusy = rbusy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 5) == 0);
         drive(rid, rex, rbr, rbusy);
         #3;
         if (rbusy)                              exp_ctl = C_HOLD;
         else if (rbr)                           exp_ctl = C_FLUSH;
         else if (model_lu(rid, rex) && !m_just) exp_ctl = C_STALL;
         else                                    exp_ctl = C_DEF;
         chk_ctl("rnd_ctl", exp_ctl);
         chk("rnd_stall",   stall_cnt,   (m_st > 65535) ? 65535 : m_st);
         chk("rnd_flush",   flush_cnt,   (m_fl > 65535) ? 65535 : m_fl);
         chk("rnd_stall_w", w_stall_cnt, (m_st > 15) ? 15 : m_st);
         chk("rnd_flush_w", w_flush_cnt, (m_fl > 15) ? 15 : m_fl);
         chk("rnd_hang",    hang_err,    m_h64);
         chk("rnd_hang_w",  w_hang_err,  m_h4);
         m_just = (exp_ctl == C_STALL);
         if (exp_ctl == C_STALL) m_st++;
         if (exp_ctl == C_FLUSH) m_fl++;
         m_run = rbusy ? m_run + 1 : 0;
         if (m_run >= 4)  m_h4  = 1'b1;
         if (m_run >= 64) m_h64 = 1'b1;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It is the stalling counterpart of the forwarding unit: the forwarding unit resolves RAW hazards by bypassing, and this block handles the cases bypassing cannot. It detects load-use hazards between ID and EX, flushes on taken branches and jumps, and freezes the whole pipe while data memory is busy. It drives the write-enables and bubble/flush controls of the PC and pipeline registers, and keeps saturating stall/flush counters plus a memory-hang watchdog.

## Interface
- MAX_WAIT, 64: mem_busy cycles tolerated before hang_err sets.
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-high.
- id_inst  in  32  instruction in IF/ID.
- ex_inst  in  32  instruction in ID/EX.
- br_taken  in  1  EX-stage branch/jump redirect.
- mem_busy  in  1  data memory not ready this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID cleared to NOP (0x00000013).
- idex_bubble  out  1  ID/EX loaded with NOP instead of ID contents.
- pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.
- hang_err  out  1  sticky watchdog error.

## Operation
- States: RUN, LU_STALL, MEM_WAIT. The state register is asynchronous-reset to RUN.
- Load-use condition lu:
  - ex_inst[6:0]==7'b0000011 and rd=ex_inst[11:7]!=0;
  - and either uses_rs1(id_inst) with id_inst[19:15]==rd, or uses_rs2(id_inst) with id_inst[24:20]==rd.
- uses_rs1: every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- uses_rs2: only opcodes 0110011, 0100011 and 1100011.
- Priority, highest first: rstn, mem_busy, br_taken, lu.
- Outputs are combinational from state and inputs. Default is pc_write=1, ifid_write=1, all other controls 0.
- mem_busy=1, any state:
  - pipe_hold=1, pc_write=0, ifid_write=0, no bubble, no flush;
  - next state MEM_WAIT;
  - the wait counter increments, saturating at MAX_WAIT.
- br_taken=1 without mem_busy:
  - ifid_flush=1, idex_bubble=1, pc_write=1 (target is loaded);
  - flush_cnt increments;
  - next state RUN. A flush overrides a simultaneous lu, because the dependent instruction is discarded.
- lu=1 without mem_busy or br_taken, in RUN or MEM_WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1;
  - stall_cnt increments;
  - next state LU_STALL.
- LU_STALL: lu is ignored, since ex_inst is now the bubble. Outputs are the defaults and the next state is RUN. mem_busy and br_taken still take priority as above.
- MEM_WAIT with mem_busy=0: clear the wait counter, then evaluate br_taken and lu as in RUN.
- Watchdog: when the wait counter reaches MAX_WAIT while mem_busy=1, hang_err sets. It clears only on rstn.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- While rstn=1 (asynchronous):
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0;
  - stall_cnt=0, flush_cnt=0, hang_err=0, state RUN.
- After rstn deasserts: first rising edge in RUN, with default outputs.
- Stall/flush controls take effect in the same cycle as detection, so the pipeline registers sample them on that cycle's edge.
- A load-use stall is exactly 1 cycle; the dependent instruction reaches EX with a 2-cycle gap and picks up its operand via MEM/WB forwarding.
- A flush costs 2 cycles: the wrong-path IF and ID slots.
- Counters update on the edge ending the event cycle, so they are visible the next cycle.
- mem_busy arriving during LU_STALL: hold has priority; after mem_busy drops, the state returns through MEM_WAIT to RUN, and lu is re-evaluated. That lu is false because EX holds the bubble.

## Test plan
- Load-use on rs1:
  - Stimulus: ex_inst=0x0000A283 (lw x5,0(x1)), id_inst=0x00728333 (add x6,x5,x7).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; next cycle, with ex_inst=0x00000013, all defaults; stall_cnt=1.
- No false stalls:
  - Stimulus 1: ex_inst=0x0000A003 (lw x0). Stimulus 2: id_inst=0x0002A2B7 (lui x5, rs1 field=5), with ex_inst loading x5.
  - Response: both give defaults only; stall_cnt=0.
- Branch beats load-use:
  - Stimulus: br_taken=1 together with the lu pair above.
  - Response: ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- Memory wait:
  - Stimulus: mem_busy=1 for 5 cycles during a load-use pair.
  - Response: pipe_hold=1 and pc_write=0 for all 5 cycles; then a 1-cycle stall; stall_cnt=1, hang_err=0.
- Watchdog:
  - Stimulus: MAX_WAIT=4, mem_busy held for 10 cycles.
  - Response: hang_err=1 once the counter reaches 4; it stays 1 after mem_busy drops and clears only on rstn.
- Async reset mid-stall:
  - Stimulus: rstn pulse between clock edges during LU_STALL.
  - Response: outputs immediately take their reset values; counters=0; state RUN after release.
